// File: rtl/adsr_envelope_pkg.sv
// adsr_envelope_pkg: shared widths and envelope state encodings.
package adsr_envelope_pkg;
    localparam int ENV_ACC_W = 16;
    localparam int SAMPLE_W  = 8;
    typedef enum logic [2:0] {
        ENV_IDLE    = 3'd0,
        ENV_ATTACK  = 3'd1,
        ENV_DECAY   = 3'd2,
        ENV_SUSTAIN = 3'd3,
        ENV_RELEASE = 3'd4
    } env_state_t;
endpackage

// File: rtl/env_tick_gen.sv
// env_tick_gen: one-cycle tick every 2^PRESCALE_BITS clocks (constant 1 when PRESCALE_BITS=0).
module env_tick_gen #(
    parameter int PRESCALE_BITS = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    generate
        if (PRESCALE_BITS == 0) begin : g_every
            assign tick = 1'b1;
        end else begin : g_cnt
            logic [PRESCALE_BITS-1:0] cnt;
            always_ff @(posedge clk or posedge rst)
                if (rst) cnt <= '0;
                else     cnt <= cnt + 1'b1;
            assign tick = &cnt;
        end
    endgenerate
endmodule

// File: rtl/adsr_envelope.sv
// adsr_envelope: gate-driven ADSR envelope scaling an 8-bit sample for the DAC.
module adsr_envelope
    import adsr_envelope_pkg::*;
#(
    parameter int PRESCALE_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 gate,
    input  logic [7:0]           attack_rate,
    input  logic [7:0]           decay_rate,
    input  logic [7:0]           sustain_level,
    input  logic [7:0]           release_rate,
    input  logic [SAMPLE_W-1:0]  wave_in,
    output logic [SAMPLE_W-1:0]  wave_out,
    output logic [7:0]           env_level,
    output logic [2:0]           env_state
);
    logic                 tick, gate_d, rise, fall;
    env_state_t           state, state_n;
    logic [ENV_ACC_W-1:0] acc, acc_n;
    logic [7:0]           rate;
    logic [ENV_ACC_W:0]   step, sum, diff, target;

    env_tick_gen #(.PRESCALE_BITS(PRESCALE_BITS)) u_tick (.clk(clk), .rst(rst), .tick(tick));

    // 17-bit arithmetic keeps every overflow/underflow comparison wrap-free
    always_comb begin
        rise    = gate & ~gate_d;
        fall    = ~gate & gate_d;
        rate    = state == ENV_ATTACK ? attack_rate : state == ENV_DECAY ? decay_rate : release_rate;
        step    = {9'd0, rate} + 17'd1;
        sum     = {1'b0, acc} + step;
        diff    = {1'b0, acc} - step;
        target  = {1'b0, sustain_level, 8'h00};
        state_n = state;
        acc_n   = acc;
        if (rise)
            state_n = ENV_ATTACK;
        else if (fall && state inside {ENV_ATTACK, ENV_DECAY, ENV_SUSTAIN})
            state_n = ENV_RELEASE;
        else
            case (state)
                ENV_ATTACK: if (tick) begin
                    acc_n   = sum[ENV_ACC_W] ? 16'hFFFF : sum[ENV_ACC_W-1:0];
                    state_n = sum[ENV_ACC_W] ? ENV_DECAY : ENV_ATTACK;
                end
                ENV_DECAY: if (tick) begin
                    acc_n   = {1'b0, acc} <= target + step ? target[ENV_ACC_W-1:0] : diff[ENV_ACC_W-1:0];
                    state_n = {1'b0, acc} <= target + step ? ENV_SUSTAIN : ENV_DECAY;
                end
                ENV_SUSTAIN: acc_n = target[ENV_ACC_W-1:0];
                ENV_RELEASE: if (tick) begin
                    acc_n   = {1'b0, acc} <= step ? '0 : diff[ENV_ACC_W-1:0];
                    state_n = {1'b0, acc} <= step ? ENV_IDLE : ENV_RELEASE;
                end
                default: acc_n = '0;
            endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state    <= ENV_IDLE;
            acc      <= '0;
            gate_d   <= 1'b0;
            wave_out <= '0;
        end else begin
            state    <= state_n;
            acc      <= acc_n;
            gate_d   <= gate;
            wave_out <= 8'(({8'd0, wave_in} * ({8'd0, env_level} + 16'd1)) >> 8);
        end

    assign env_level = acc[ENV_ACC_W-1:8];
    assign env_state = state;
endmodule

// File: tb/tb_adsr_envelope.sv
// tb_adsr_envelope: directed ADSR stimulus checked against an arithmetic envelope model.
module tb_adsr_envelope;
    logic       clk = 0, rst = 1, gate = 0, gate2 = 0;
    logic [7:0] attack_rate = 8'hFF, decay_rate = 8'h0F, sustain_level = 8'h80;
    logic [7:0] release_rate = 8'h7F, wave_in = 8'hFF;
    logic [7:0] wave_out, env_level, wave_out2, env_level2;
    logic [2:0] env_state, env_state2;
    int checks = 0, errors = 0;
    int m_acc = 0, m_st = 0, m_wave = 0;
    bit m_gd = 0;

    always #5 clk = ~clk;

    adsr_envelope #(.PRESCALE_BITS(0)) dut (
        .clk(clk), .rst(rst), .gate(gate), .attack_rate(attack_rate), .decay_rate(decay_rate),
        .sustain_level(sustain_level), .release_rate(release_rate), .wave_in(wave_in),
        .wave_out(wave_out), .env_level(env_level), .env_state(env_state));

    adsr_envelope #(.PRESCALE_BITS(4)) dut_slow (
        .clk(clk), .rst(rst), .gate(gate2), .attack_rate(attack_rate), .decay_rate(decay_rate),
        .sustain_level(sustain_level), .release_rate(release_rate), .wave_in(wave_in),
        .wave_out(wave_out2), .env_level(env_level2), .env_state(env_state2));

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Envelope model for the tick-every-cycle instance: integer level, state numbers from the port map
    always @(posedge clk or posedge rst) begin
        int s, t, na, ns;
        if (rst) begin
            m_acc <= 0; m_st <= 0; m_wave <= 0; m_gd <= 0;
        end else begin
            t  = sustain_level * 256;
            na = m_acc;
            ns = m_st;
            if (gate && !m_gd) ns = 1;
            else if (!gate && m_gd && m_st inside {1, 2, 3}) ns = 4;
            else if (m_st == 1) begin
                s = attack_rate + 1;
                if (m_acc + s > 65535) begin na = 65535; ns = 2; end else na = m_acc + s;
            end else if (m_st == 2) begin
                s = decay_rate + 1;
                if (m_acc <= t + s) begin na = t; ns = 3; end else na = m_acc - s;
            end else if (m_st == 3) na = t;
            else if (m_st == 4) begin
                s = release_rate + 1;
                if (m_acc <= s) begin na = 0; ns = 0; end else na = m_acc - s;
            end
            m_acc  <= na;
            m_st   <= ns;
            m_wave <= (wave_in * (m_acc / 256 + 1)) / 256;
            m_gd   <= gate;
        end
    end

    always @(negedge clk)
        if (!rst) begin
            check("model env_level", env_level, m_acc / 256);
            check("model env_state", env_state, m_st);
            check("model wave_out", wave_out, m_wave);
        end

    task automatic wait_state(input int st, input int budget, output int n);
        n = 0;
        while (env_state != st && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (env_state != st) check("wait_state timeout", env_state, st);
    endtask

    initial begin
        int n, last, prev;
        repeat (2) @(negedge clk);
        check("reset wave_out", wave_out, 0);
        check("reset env_level", env_level, 0);
        check("reset env_state", env_state, 0);
        rst = 0; gate = 1;
        repeat (10) @(negedge clk);
        check("pre-reset attack", env_state, 1);
        #2 rst = 1;
        #1;
        check("async wave_out", wave_out, 0);
        check("async env_level", env_level, 0);
        check("async env_state", env_state, 0);
        @(negedge clk) gate = 0;
        @(negedge clk) rst = 0;
        @(negedge clk) check("idle after reset", env_state, 0);
        gate = 1;
        @(negedge clk);
        check("attack entry state", env_state, 1);
        check("attack entry level", env_level, 0);
        wait_state(2, 400, n);
        check("attack ticks", n, 256);
        check("attack peak level", env_level, 8'hFF);
        check("full-scale passthrough", wave_out, 8'hFF);
        wait_state(3, 5000, n);
        check("sustain level", env_level, 8'h80);
        @(negedge clk) check("sustain wave_out", wave_out, 8'h80);
        sustain_level = 8'h40;
        @(negedge clk) check("sustain tracks", env_level, 8'h40);
        sustain_level = 8'h80;
        @(negedge clk);
        gate = 0;
        @(negedge clk);
        check("release entry state", env_state, 4);
        check("release entry level", env_level, 8'h80);
        wait_state(0, 400, n);
        check("release ticks", n, 256);
        @(negedge clk) check("idle wave_out", wave_out, 0);
        gate = 1; n = 0;
        while (env_level < 8'h40 && n < 200) begin @(negedge clk); n++; end
        gate = 0; n = 0;
        while (env_level != 8'h30 && n < 400) begin @(negedge clk); n++; end
        check("release reaches 30", env_level, 8'h30);
        gate = 1;
        @(negedge clk);
        check("retrigger state", env_state, 1);
        check("retrigger holds level", env_level, 8'h30);
        @(negedge clk) check("retrigger climbs", env_level, 8'h31);
        wait_state(3, 5000, n);
        gate = 0;
        wait_state(0, 1000, n);
        gate2 = 1; n = 0; last = -1; prev = env_level2;
        while (env_state2 != 2 && n < 5000) begin
            @(negedge clk);
            n++;
            if (env_level2 != prev) begin
                if (last >= 0) check("prescale spacing", n - last, 16);
                last = n;
                prev = env_level2;
            end
        end
        check("prescale reaches decay", env_state2, 2);
        check("prescale peak", env_level2, 8'hFF);
        if (n < 4082 || n > 4097) check("prescale attack clks", n, 4096);
        else check("prescale attack clks in range", 1, 1 + (n - 4082) / 16);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
